// File: rtl/q_update_pipe_pkg.sv
// q_update_pipe_pkg: shared parameters, types and saturating arithmetic for the Q-update pipeline.
package q_update_pipe_pkg;
   localparam int DATA_WIDTH  = 16;
   localparam int FRAC_BITS   = 8;
   localparam int ACTIONS     = 4;
   localparam int STATE_WIDTH = 8;
   localparam int ACT_WIDTH   = $clog2(ACTIONS);
   localparam logic signed [DATA_WIDTH-1:0] Q_ONE = DATA_WIDTH'(1 << FRAC_BITS);
   localparam logic signed [DATA_WIDTH-1:0] Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] Q_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   typedef logic signed [DATA_WIDTH-1:0] q_t;
   typedef logic [STATE_WIDTH-1:0] state_t;
   typedef logic [ACT_WIDTH-1:0] act_t;
   typedef struct packed {
      state_t s;
      act_t   a;
   } addr_t;
   // Clamp a DW+1 bit sum: overflow shows as the two top bits disagreeing.
   function automatic q_t sat(input logic signed [DATA_WIDTH:0] x);
      return (x[DATA_WIDTH] != x[DATA_WIDTH-1]) ? (x[DATA_WIDTH] ? Q_MIN : Q_MAX) : q_t'(x[DATA_WIDTH-1:0]);
   endfunction
   function automatic q_t sat_add(input q_t a, input q_t b);
      return sat({a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b});
   endfunction
   function automatic q_t sat_sub(input q_t a, input q_t b);
      return sat({a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b});
   endfunction
endpackage

// File: rtl/q_update_pipe_mul.sv
// fx_mul_rs: signed fixed-point multiply, round half toward +inf, saturate back to DW bits.
module fx_mul_rs #(
   parameter int DW = 16,
   parameter int FB = 8
) (
   input  logic signed [DW-1:0] i_a,
   input  logic signed [DW-1:0] i_b,
   output logic signed [DW-1:0] o_p
);
   logic signed [2*DW-1:0] w_prod;
   logic signed [2*DW-1:0] w_rnd;
   logic signed [2*DW-1:0] w_sh;
   logic                   w_ovf;
   assign w_prod = i_a * i_b;
   assign w_rnd  = w_prod + (2*DW)'(1 << (FB-1));
   assign w_sh   = w_rnd >>> FB;
   // In range only when all bits from DW-1 upward are copies of the sign.
   assign w_ovf  = !((&w_sh[2*DW-1:DW-1]) || !(|w_sh[2*DW-1:DW-1]));
   assign o_p    = w_ovf ? (w_sh[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                         : w_sh[DW-1:0];
endmodule

// File: rtl/q_update_pipe.sv
// q_update_pipe: 3-stage valid/ready Q-learning update, Q += alpha*(r + gamma*maxQ - Q),
// carrying the (state, action) write-back address alongside the value.
module q_update_pipe
   import q_update_pipe_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [DATA_WIDTH-1:0]  max_q,
   input  logic signed [DATA_WIDTH-1:0]  q_old,
   input  logic signed [DATA_WIDTH-1:0]  reward,
   input  logic signed [DATA_WIDTH-1:0]  alpha,
   input  logic signed [DATA_WIDTH-1:0]  gamma,
   input  logic        [STATE_WIDTH-1:0] state_in,
   input  logic        [ACT_WIDTH-1:0]   action_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [DATA_WIDTH-1:0]  q_new,
   output logic        [STATE_WIDTH-1:0] state_out,
   output logic        [ACT_WIDTH-1:0]   action_out
);
   logic  r_v1, r_v2, r_v3;
   q_t    r_tgt, r_q1, r_a1;
   q_t    r_td, r_q2, r_a2;
   q_t    r_q3;
   addr_t r_ad1, r_ad2, r_ad3;
   q_t    w_gm, w_atd;
   logic  w_adv;
   // Whole pipe moves in lockstep; bubbles travel like data.
   assign w_adv    = !r_v3 || out_ready;
   assign in_ready = w_adv;
   fx_mul_rs #(.DW(DATA_WIDTH), .FB(FRAC_BITS)) u_mul_gm (
      .i_a(gamma),
      .i_b(max_q),
      .o_p(w_gm)
   );
   fx_mul_rs #(.DW(DATA_WIDTH), .FB(FRAC_BITS)) u_mul_atd (
      .i_a(r_a2),
      .i_b(r_td),
      .o_p(w_atd)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
         r_tgt <= '0;
         r_q1  <= '0;
         r_a1  <= '0;
         r_td  <= '0;
         r_q2  <= '0;
         r_a2  <= '0;
         r_q3  <= '0;
         r_ad1 <= '0;
         r_ad2 <= '0;
         r_ad3 <= '0;
      end else if (w_adv) begin
         r_v1  <= in_valid;
         r_tgt <= sat_add(reward, w_gm);
         r_q1  <= q_old;
         r_a1  <= alpha;
         r_ad1 <= '{s: state_in, a: action_in};
         r_v2  <= r_v1;
         r_td  <= sat_sub(r_tgt, r_q1);
         r_q2  <= r_q1;
         r_a2  <= r_a1;
         r_ad2 <= r_ad1;
         r_v3  <= r_v2;
         r_q3  <= sat_add(r_q2, w_atd);
         r_ad3 <= r_ad2;
      end
   end
   assign out_valid  = r_v3;
   assign q_new      = r_q3;
   assign state_out  = r_ad3.s;
   assign action_out = r_ad3.a;
endmodule

// File: tb/tb_q_update_pipe.sv
// tb_q_update_pipe: scoreboard bench for the Q-update pipeline (DW=16, FRAC=8).
module tb_q_update_pipe;
   localparam int DW = 16;
   localparam int FB = 8;
   localparam int SW = 8;
   localparam int AW = 2;
   localparam longint QMAX = 32767;
   localparam longint QMIN = -32768;
   typedef struct packed {
      logic [DW-1:0] q;
      logic [SW-1:0] s;
      logic [AW-1:0] a;
   } exp_t;
   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid, in_ready, out_valid, out_ready;
   logic signed [DW-1:0] max_q, q_old, reward, alpha, gamma, q_new;
   logic        [SW-1:0] state_in, state_out;
   logic        [AW-1:0] action_in, action_out;
   int                   n_chk = 0;
   int                   n_fail = 0;
   exp_t                 sb[$];
   always #5 clk = ~clk;
   q_update_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .max_q(max_q), .q_old(q_old), .reward(reward), .alpha(alpha), .gamma(gamma),
      .state_in(state_in), .action_in(action_in), .out_valid(out_valid), .out_ready(out_ready),
      .q_new(q_new), .state_out(state_out), .action_out(action_out)
   );
   function automatic longint clampq(input longint x);
      return x > QMAX ? QMAX : (x < QMIN ? QMIN : x);
   endfunction
   function automatic longint sx(input logic [DW-1:0] x);
      return longint'($signed(x));
   endfunction
   function automatic longint rmul(input longint a, input longint b);
      return clampq((a * b + (longint'(1) << (FB-1))) >>> FB);
   endfunction
   function automatic exp_t model(input logic [DW-1:0] r, g, m, qo, al,
                                  input logic [SW-1:0] s, input logic [AW-1:0] a);
      longint t, td, qn;
      t  = clampq(sx(r) + rmul(sx(g), sx(m)));
      td = clampq(t - sx(qo));
      qn = clampq(sx(qo) + rmul(sx(al), td));
      model.q = qn[DW-1:0];
      model.s = s;
      model.a = a;
   endfunction
   task automatic drive_rand;
      max_q     = DW'($urandom);
      q_old     = DW'($urandom);
      reward    = DW'($urandom);
      alpha     = DW'($urandom);
      gamma     = DW'($urandom);
      state_in  = SW'($urandom);
      action_in = AW'($urandom);
   endtask
   task automatic push_beat;
      sb.push_back(model(reward, gamma, max_q, q_old, alpha, state_in, action_in));
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_chk++; if (q_new !== '0) begin n_fail++; $display("FAIL reset_q_new got %h want 0000", q_new); end
      n_chk++; if (state_out !== '0) begin n_fail++; $display("FAIL reset_state got %h want 00", state_out); end
      n_chk++; if (action_out !== '0) begin n_fail++; $display("FAIL reset_action got %h want 0", action_out); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      rst = 1'b0;
   endtask

   // Nominal, saturation and rounding vectors: r, gamma, max_q, q_old, alpha, expected q_new.
   task automatic test_directed;
      logic [DW-1:0] vec [4][6];
      int lat;
      vec = '{'{16'h0100, 16'h00C0, 16'h0200, 16'h0100, 16'h0080, 16'h01C0},
              '{16'h7F00, 16'h0100, 16'h7FFF, 16'h8000, 16'h0100, 16'hFFFF},
              '{16'h0000, 16'h0080, 16'hFFFF, 16'h0000, 16'h0100, 16'h0000},
              '{16'h0000, 16'h0080, 16'h0003, 16'h0000, 16'h0100, 16'h0002}};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         reward = vec[i][0]; gamma = vec[i][1]; max_q = vec[i][2]; q_old = vec[i][3]; alpha = vec[i][4];
         state_in = SW'(8'h10 + i); action_in = AW'(i);
         in_valid = 1'b1;
         @(negedge clk);
         n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_accept got %b want 1", i, in_ready); end
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!out_valid && lat < 10);
         n_chk++; if (lat != 3) begin n_fail++; $display("FAIL dir%0d_latency got %0d want 3", i, lat); end
         n_chk++; if (q_new !== vec[i][5]) begin n_fail++; $display("FAIL dir%0d_q_new got %h want %h", i, q_new, vec[i][5]); end
         n_chk++; if (state_out !== SW'(8'h10 + i) || action_out !== AW'(i)) begin
            n_fail++; $display("FAIL dir%0d_addr got %h/%h want %h/%h", i, state_out, action_out, 8'h10 + i, i);
         end
      end
   endtask

   task automatic test_back_to_back;
      int sent, got;
      logic acc, stall_prev;
      exp_t held, e;
      sb.delete();
      sent = 0; got = 0; stall_prev = 1'b0;
      @(posedge clk); #1;
      drive_rand(); in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         @(negedge clk);
         if (out_valid && !out_ready) begin
            n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d got %b want 0", cyc, in_ready); end
            if (stall_prev) begin
               n_chk++; if ({q_new, state_out, action_out} !== held) begin
                  n_fail++; $display("FAIL bp_hold cyc%0d got %h want %h", cyc, {q_new, state_out, action_out}, held);
               end
            end
            held = {q_new, state_out, action_out};
            stall_prev = 1'b1;
         end else stall_prev = 1'b0;
         if (out_valid && out_ready) begin
            n_chk++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL bp_extra got %h want none", q_new); end
            else begin
               e = sb.pop_front();
               if ({q_new, state_out, action_out} !== e) begin
                  n_fail++; $display("FAIL bp_data%0d got %h want %h", got, {q_new, state_out, action_out}, e);
               end
            end
            got++;
         end
         acc = in_valid && in_ready;
         if (acc) begin push_beat(); sent++; end
         @(posedge clk); #1;
         out_ready = !(cyc >= 4 && cyc < 8);
         if (acc) begin
            if (sent < 6) drive_rand(); else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_chk++; if (got != 6 || sb.size() != 0) begin
         n_fail++; $display("FAIL bp_count got %0d left %0d want 6 left 0", got, sb.size());
      end
   endtask

   task automatic test_reset_mid;
      exp_t e;
      int lat;
      sb.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         drive_rand(); in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
      #1 rst = 1'b1;
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
      n_chk++; if (q_new !== '0) begin n_fail++; $display("FAIL rst_async_q_new got %h want 0000", q_new); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      drive_rand(); in_valid = 1'b1;
      e = model(reward, gamma, max_q, q_old, alpha, state_in, action_in);
      @(negedge clk);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_post_accept got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 10);
      n_chk++; if (lat != 3) begin n_fail++; $display("FAIL rst_post_latency got %0d want 3", lat); end
      n_chk++; if ({q_new, state_out, action_out} !== e) begin
         n_fail++; $display("FAIL rst_post_data got %h want %h", {q_new, state_out, action_out}, e);
      end
   endtask

   task automatic test_throughput;
      int sent, got, gaps;
      exp_t e;
      sb.delete();
      sent = 0; got = 0; gaps = 0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      drive_rand(); in_valid = 1'b1;
      for (int cyc = 0; cyc < 200 && got < 100; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            n_chk++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL tp_extra got %h want none", q_new); end
            else begin
               e = sb.pop_front();
               if ({q_new, state_out, action_out} !== e) begin
                  n_fail++; $display("FAIL tp_data%0d got %h want %h", got, {q_new, state_out, action_out}, e);
               end
            end
            got++;
         end else if (got > 0) gaps++;
         if (in_valid && in_ready) begin push_beat(); sent++; end
         @(posedge clk); #1;
         if (sent < 100) drive_rand(); else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      n_chk++; if (got != 100 || gaps != 0) begin
         n_fail++; $display("FAIL tp_stream got %0d results %0d gaps want 100 results 0 gaps", got, gaps);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      max_q = '0; q_old = '0; reward = '0; alpha = '0; gamma = '0; state_in = '0; action_in = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_throughput();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
